// File: rtl/cnt_arb_pkg.sv
// Shared types and default sizing for the counter access arbiter.
// Opcode encoding matches the 2-bit req_op field of each requester.
package cnt_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_INC   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or above ptr, wrapping.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr) + off) % N;
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = IW'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_access_arbiter.sv
// Shared counter with round-robin access from NUM_REQ requesters and an
// optional free-running increment; one op per two cycles via IDLE/RESP.
module cnt_access_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    input  logic                       free_run_en,
    output logic [WIDTH-1:0]           count_out
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    state_e               state, state_nxt;
    logic [IW-1:0]        ptr, ptr_nxt;
    logic [WIDTH-1:0]     counter, counter_nxt;
    logic [IW-1:0]        rsp_id_q, rsp_id_nxt;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_nxt;

    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        win_idx;
    logic                 win_any;
    logic                 handshake;
    op_e                  win_op;
    logic [WIDTH-1:0]     win_data;
    logic [WIDTH-1:0]     post_op;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        int unsigned sel;
        sel      = 32'(win_idx);
        win_op   = op_e'(req_op[sel*2 +: 2]);
        win_data = req_data[sel*WIDTH +: WIDTH];
        post_op  = counter;
        case (win_op)
            OP_READ:  post_op = counter;
            OP_INC:   post_op = counter + 1'b1;
            OP_LOAD:  post_op = win_data;
            OP_CLEAR: post_op = '0;
            default:  post_op = counter;
        endcase
    end

    // Grants are suppressed while reset is held so nothing is offered to a
    // requester that could be mistaken for an accept.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        rsp_id_nxt   = rsp_id_q;
        rsp_data_nxt = rsp_data_q;
        req_ready    = '0;
        handshake    = 1'b0;
        rsp_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && win_any) begin
                    req_ready    = grant;
                    handshake    = 1'b1;
                    state_nxt    = RESP;
                    rsp_id_nxt   = win_idx;
                    rsp_data_nxt = post_op;
                    ptr_nxt      = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A committed op overrides free-run so the counter never moves twice.
    always_comb begin
        counter_nxt = counter;
        if (handshake) begin
            counter_nxt = post_op;
        end else if (free_run_en) begin
            counter_nxt = counter + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            counter    <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            counter    <= counter_nxt;
            rsp_id_q   <= rsp_id_nxt;
            rsp_data_q <= rsp_data_nxt;
        end
    end

    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign count_out = counter;

endmodule

// File: tb/tb_cnt_access_arbiter.sv
// Randomized and directed checks of cnt_access_arbiter against a
// transaction-level model of the counter, pointer and pending response.
module tb_cnt_access_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   req_op;
    logic [W*N-1:0]   req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
    logic             free_run_en;
    logic [W-1:0]     count_out;

    cnt_access_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .free_run_en (free_run_en),
        .count_out   (count_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Requester intent and model state
    bit v[N];
    int op[N];
    int dat[N];
    int m_cnt, m_ptr, m_rid, m_rdata;
    bit m_pend;
    int grant_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = v[i];
            req_op[2*i +: 2]   = op[i][1:0];
            req_data[W*i +: W] = dat[i][W-1:0];
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_ptr  = 0;
        m_pend = 0;
        m_rid  = 0;
        m_rdata = 0;
        for (int i = 0; i < N; i++) begin
            v[i] = 0; op[i] = 0; dat[i] = 0;
        end
    endtask

    // Called at a negedge: apply inputs, check, model the next rising edge.
    task automatic step();
        int win;
        int exp_ready;
        win = -1;
        drive();
        #1;
        if (!m_pend) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (win < 0 && v[c]) win = c;
            end
        end
        exp_ready = (win >= 0) ? (1 << win) : 0;
        check("req_ready", 32'(req_ready), exp_ready);
        check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
        if (m_pend) begin
            check("rsp_id", 32'(rsp_id), m_rid);
            check("rsp_data", 32'(rsp_data), m_rdata);
        end
        check("count_out", 32'(count_out), m_cnt);
        if (win >= 0) begin
            case (op[win])
                1: m_cnt = (m_cnt + 1) % 256;
                2: m_cnt = dat[win];
                3: m_cnt = 0;
                default: ;
            endcase
            m_pend  = 1;
            m_rid   = win;
            m_rdata = m_cnt;
            m_ptr   = (win + 1) % N;
            grant_log.push_back(win);
            v[win]  = 0;
        end else begin
            if (free_run_en) m_cnt = (m_cnt + 1) % 256;
            if (m_pend && rsp_ready) m_pend = 0;
        end
        @(negedge clk);
    endtask

    task automatic req(input int i, input int o, input int d);
        v[i] = 1; op[i] = o; dat[i] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        free_run_en = 1'b0;
        rsp_ready   = 1'b1;
        model_clear();
        req(0, 1, 0);
        req(2, 2, 8'h55);
        drive();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_count", 32'(count_out), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        do_reset();

        // Free-run wrap
        free_run_en = 1'b1;
        for (int c = 0; c < 260; c++) step();
        check("freerun_260", 32'(count_out), 4);

        // LOAD then INC on requester 0
        do_reset();
        free_run_en = 1'b0;
        rsp_ready   = 1'b1;
        req(0, 2, 8'h7F);
        step();
        #1;
        check("load_rsp_id", 32'(rsp_id), 0);
        check("load_rsp_data", 32'(rsp_data), 8'h7F);
        @(negedge clk);
        m_pend = 0;
        req(0, 1, 0);
        step();
        #1;
        check("inc_rsp_valid", 32'(rsp_valid), 1);
        check("inc_rsp_data", 32'(rsp_data), 8'h80);
        @(negedge clk);
        m_pend = 0;

        // Round-robin order with all requesters reading
        do_reset();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) if (!v[i]) req(i, 0, 0);
            step();
        end
        begin
            int exp_order[5] = '{0, 1, 2, 3, 0};
            for (int g = 0; g < 5; g++) check("rr_order", grant_log[g], exp_order[g]);
        end

        // Held response with free-run running
        do_reset();
        free_run_en = 1'b1;
        rsp_ready   = 1'b0;
        req(1, 2, 8'h33);
        req(3, 0, 0);
        step();
        for (int c = 0; c < 5; c++) step();
        check("hold_rsp_data", 32'(rsp_data), 8'h33);
        check("hold_count", 32'(count_out), 8'h38);
        rsp_ready = 1'b1;
        step();
        step();
        step();

        // CLEAR beats free-run in the commit cycle
        do_reset();
        free_run_en = 1'b0;
        req(1, 2, 8'h10);
        step();
        step();
        free_run_en = 1'b1;
        req(2, 3, 0);
        step();
        check("clear_commit", 32'(count_out), 0);
        step();
        check("clear_next", 32'(count_out), 1);

        // Reset while a response is pending
        rsp_ready = 1'b0;
        req(0, 1, 0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_resp_valid", 32'(rsp_valid), 0);
        check("rst_resp_count", 32'(count_out), 0);
        model_clear();
        free_run_en = 1'b0;
        rsp_ready   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(2, 0) == 0)
                    req(i, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)));
            end
            free_run_en = 1'($urandom_range(1, 0));
            rsp_ready   = ($urandom_range(2, 0) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
